mega_ctrl: RTL
==============

MEGA_CTRL -- requirements
Module: mega_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: CD, 12, pixel color depth; ADDR, 12, sprite RAM address width; DEPTH, 4096, sprite RAM entries (2**ADDR).
REQ-002 Ports (name  direction  width  meaning) SHALL be, clock and reset first:
  clk  in  1  single system clock, rising edge
  reset_n  in  1  reset, asynchronous assert, active-low
  cs  in  1  bus slot select
  write  in  1  bus write strobe, qualified by cs
  addr  in  14  bus word address; addr[13]=1 register space, addr[13]=0 sprite RAM
  wr_data  in  32  bus write data
  rd_data  out  32  status readback
  frame_start  in  1  one-cycle pulse at first pixel of each frame
  x0  out  11  active sprite origin x
  y0  out  11  active sprite origin y
  we  out  1  sprite RAM write enable
  addr_w  out  ADDR  sprite RAM write address
  pixel_in  out  CD  sprite RAM write data
  busy  out  1  fill engine active
REQ-003 One clock, clk; reset is asynchronous and active-low on reset_n.

Function
REQ-004 Bus write = cs & write; reads are side-effect free.
REQ-005 RAM write (addr[13]=0): one cycle later we=1, addr_w=addr[ADDR-1:0], pixel_in=wr_data[CD-1:0] (registered, latency 1).
REQ-006 Register writes (addr[13]=1, decode addr[1:0]): 0 -> x_shadow=wr_data[10:0]; 1 -> y_shadow=wr_data[10:0]; 2 -> set commit_pending; 3 -> fill command, color=wr_data[CD-1:0].
REQ-007 On frame_start with commit_pending=1 (value before this edge): x0<=x_shadow, y0<=y_shadow, commit_pending cleared; x0/y0 change at no other time.
REQ-008 Commit write and frame_start in same cycle: pending remains set, commit applies at next frame_start; shadow write coincident with applying frame_start: old shadow value is committed.
REQ-009 frame_cnt (16 bit) increments on every frame_start, wraps 0xFFFF->0x0000.
REQ-010 rd_data (combinational) = {frame_cnt[15:0], 14'b0, commit_pending, busy}, independent of addr.
REQ-011 Fill FSM states IDLE, FILL; IDLE->FILL on fill command (fill_addr=0, color latched, busy=1 next cycle).
REQ-012 In FILL, each cycle with no bus RAM write: registered outputs we=1, addr_w=fill_addr, pixel_in=color; fill_addr++.
REQ-013 Arbitration: bus RAM write has strict priority; fill stalls that cycle, fill_addr unchanged, no fill write lost or duplicated.
REQ-014 FILL->IDLE after write of address DEPTH-1 is issued; busy falls same edge that registers the last fill write; uninterrupted fill = DEPTH cycles of we.
REQ-015 Fill command while busy=1: ignored (color and fill_addr unchanged).
REQ-016 Register writes (shadow, commit) proceed normally during FILL.
REQ-017 we=0 on any cycle with neither a bus RAM write nor a fill write.

Reset
REQ-018 reset_n=0 SHALL immediately force: x0=0, y0=0, x_shadow=0, y_shadow=0, commit_pending=0, frame_cnt=0, state=IDLE, busy=0, we=0, addr_w=0, pixel_in=0.
REQ-019 Reset mid-fill aborts fill; after release block idles, no write resumes.
REQ-020 Outputs update only on clk rising edge after reset_n deasserts.

Verification
REQ-021 Write reg0=100, reg1=50, reg2, no frame_start -> x0/y0 remain 0, rd_data[1]=1; pulse frame_start -> x0=100, y0=50, rd_data[1]=0.
REQ-022 Commit write coincident with frame_start -> x0/y0 unchanged; next frame_start -> shadows applied.
REQ-023 Fill color 0xF00 with idle bus -> 4096 consecutive we cycles, addr_w 0..4095, pixel_in=0xF00, busy=0 after last.
REQ-024 During fill at fill_addr=10, bus RAM write addr 0x123 data 0x0AB -> that cycle addr_w=0x123/pixel_in=0x0AB; next cycle fill writes addr 10; total fill writes still 4096.
REQ-025 Second fill command mid-fill with color 0x00F -> ignored, all fill writes keep first color.
REQ-026 reset_n low at fill_addr=2000 -> we=0, busy=0, x0=y0=0 asynchronously; after release, no further writes; 65536 frame_start pulses -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/mega_ctrl.sv
// Sprite controller: double-buffered origin registers, frame counter,
// and a sprite RAM fill engine sharing the write port with the bus.
module mega_ctrl #(
    parameter int CD    = 12,
    parameter int ADDR  = 12,
    parameter int DEPTH = 4096
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cs,
    input  logic            write,
    input  logic [13:0]     addr,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    input  logic            frame_start,
    output logic [10:0]     x0,
    output logic [10:0]     y0,
    output logic            we,
    output logic [ADDR-1:0] addr_w,
    output logic [CD-1:0]   pixel_in,
    output logic            busy
);

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_e;

    localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [ADDR-1:0] faddr_q, faddr_d;
    logic [CD-1:0]   color_q, color_d;
    logic            we_q, we_d;
    logic [ADDR-1:0] waddr_q, waddr_d;
    logic [CD-1:0]   wdata_q, wdata_d;

    logic [10:0]     xs_q, ys_q;
    logic [10:0]     x0_q, y0_q;
    logic            pend_q;
    logic [15:0]     fcnt_q;

    logic            bus_wr, ram_wr, reg_wr;
    logic            wr_x, wr_y, wr_commit, fill_cmd;
    logic            unused_ok;

    assign bus_wr    = cs & write;
    assign ram_wr    = bus_wr & ~addr[13];
    assign reg_wr    = bus_wr & addr[13];
    assign wr_x      = reg_wr & (addr[1:0] == 2'd0);
    assign wr_y      = reg_wr & (addr[1:0] == 2'd1);
    assign wr_commit = reg_wr & (addr[1:0] == 2'd2);
    assign fill_cmd  = reg_wr & (addr[1:0] == 2'd3);
    assign unused_ok = ^{wr_data, addr};

    // Bus RAM writes win the shared port; the fill simply holds its address.
    always_comb begin
        state_d = state_q;
        faddr_d = faddr_q;
        color_d = color_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (ram_wr) begin
            we_d    = 1'b1;
            waddr_d = addr[ADDR-1:0];
            wdata_d = wr_data[CD-1:0];
        end
        unique case (state_q)
            S_IDLE: begin
                if (fill_cmd) begin
                    state_d = S_FILL;
                    faddr_d = '0;
                    color_d = wr_data[CD-1:0];
                end
            end
            S_FILL: begin
                if (!ram_wr) begin
                    we_d    = 1'b1;
                    waddr_d = faddr_q;
                    wdata_d = color_q;
                    faddr_d = faddr_q + ADDR'(1);
                    if (faddr_q == LAST) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            faddr_q <= '0;
            color_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            faddr_q <= faddr_d;
            color_q <= color_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Commits apply the shadow as it stood before this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xs_q   <= '0;
            ys_q   <= '0;
            x0_q   <= '0;
            y0_q   <= '0;
            pend_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            if (wr_x) begin
                xs_q <= wr_data[10:0];
            end
            if (wr_y) begin
                ys_q <= wr_data[10:0];
            end
            if (frame_start && pend_q) begin
                x0_q <= xs_q;
                y0_q <= ys_q;
            end
            if (wr_commit) begin
                pend_q <= 1'b1;
            end else if (frame_start) begin
                pend_q <= 1'b0;
            end
            if (frame_start) begin
                fcnt_q <= fcnt_q + 16'd1;
            end
        end
    end

    assign busy     = (state_q == S_FILL);
    assign we       = we_q;
    assign addr_w   = waddr_q;
    assign pixel_in = wdata_q;
    assign x0       = x0_q;
    assign y0       = y0_q;
    assign rd_data  = {fcnt_q, 14'b0, pend_q, busy};

endmodule
